fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Decoupling FIFO directly downstream of instruction fetch. Buffers {PC, instruction} pairs between fetch and decode/rename.
- Back-pressures fetch through push_ready_o, which drives the fetch PC enable.
- Discards all buffered, wrong-path instructions when a restore/flush is signalled.

Parameters:
- DEPTH, 8: number of entries. Must be a power of two and >= 2.
- PC_W, 64: width of stored PC.
- INSTR_W, 32: width of stored instruction.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- flush_i  in  1  restore/flush request; empties the queue.
- push_valid_i  in  1  fetch presents a valid entry.
- push_pc_i  in  PC_W  PC of the fetched instruction.
- push_instr_i  in  INSTR_W  fetched instruction word.
- push_ready_o  out  1  queue can accept an entry this cycle (drives fetch PC enable).
- pop_valid_o  out  1  head entry valid.
- pop_pc_o  out  PC_W  head PC.
- pop_instr_o  out  INSTR_W  head instruction.
- pop_ready_i  in  1  consumer takes head this cycle.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular buffer with head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus an occupancy counter count.
- Reset (reset==0 at a rising edge): head=tail=count=0; all storage cleared to 0.
- While reset is low, push_ready_o=0 and pop_valid_o=0.
- After reset: push_ready_o=1, pop_valid_o=0, pop_pc_o=0, pop_instr_o=0, count_o=0.
- push_ready_o = (count != DEPTH).
  - Derived only from registered state; no combinational path from pop_ready_i.
  - A full queue therefore refuses a push even while popping in the same cycle.
- pop_valid_o = (count != 0).
  - pop_pc_o/pop_instr_o always show the storage at head.
  - Contents are only meaningful when pop_valid_o=1.
- Push fires when push_valid_i & push_ready_o: write at tail, tail++.
- Pop fires when pop_valid_o & pop_ready_i: head++.
- count: +1 on push only, -1 on pop only, unchanged on push+pop or on neither.
- Latency: an entry pushed at edge N is visible on the pop side in the cycle after edge N (1 cycle). Order is strictly FIFO.
- Full boundary:
  - count==DEPTH → push_ready_o=0.
  - A pop at that edge makes push_ready_o=1 in the next cycle.
- Empty boundary:
  - count==0 → pop_ready_i is ignored; the head pointer does not move.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no loss. Full and empty are distinguished by count, not by pointer equality.
- Flush (flush_i=1 at an edge, reset high):
  - head=tail=count=0.
  - Any same-cycle push and pop are dropped.
  - Storage is not cleared.
  - Next cycle: pop_valid_o=0, push_ready_o=1.
  - Flush takes priority over push/pop; reset takes priority over flush.
- Reset asserted mid-operation: same result as the reset case above, regardless of occupancy or flush.
- push_valid_i while push_ready_o=0: no state change. Fetch must hold its PC.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- With the macro defined, when count==0, push_valid_i=1 and flush_i=0:
  - pop_valid_o=1 combinationally.
  - pop_pc_o/pop_instr_o = push_pc_i/push_instr_i.
  - If pop_ready_i=1 that cycle, the entry is consumed directly; count stays 0 and no write occurs.
  - If pop_ready_i=0, the entry is written normally.
  - Zero-cycle latency when empty.
- Without the macro: no combinational push→pop path; minimum latency is 1 cycle.

Test Plan:
- Reset hold: reset=0 for 2 cycles with push_valid_i=1 → push_ready_o=0, pop_valid_o=0; after release count_o=0, push_ready_o=1.
- Fill/drain: push PCs 0x0,0x4,...,0x1C (DEPTH=8) with pop_ready_i=0 → count_o=8, push_ready_o=0; a 9th push (0x20) is refused. Then pop_ready_i=1 → pops in order 0x0..0x1C, then pop_valid_o=0.
- Wrap: push 5, pop 5, push 6, pop 6 → output order matches input across the pointer wrap; count_o returns to 0.
- Simultaneous push/pop at count=3 → count stays 3; the popped PC is the oldest entry.
- Simultaneous push/pop at count=8 → push refused, count_o=7.
- Flush at count=5 with push_valid_i=1 and pop_ready_i=1 → next cycle count_o=0, pop_valid_o=0; the next pushed PC 0x100 is the first one popped.
- Bypass (macro defined): empty queue, push PC 0x40 with pop_ready_i=1 → pop_pc_o=0x40 and pop_valid_o=1 in the same cycle; count_o stays 0. Without the macro, pop_valid_o rises one cycle later.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: {PC, instr} decoupling FIFO between fetch and decode.
// Define FETCH_QUEUE_BYPASS_EN for a zero-latency push-to-pop path when empty.
module fetch_queue #(
  parameter int DEPTH   = 8,
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   push_valid_i,
  input  logic [PC_W-1:0]        push_pc_i,
  input  logic [INSTR_W-1:0]     push_instr_i,
  output logic                   push_ready_o,
  output logic                   pop_valid_o,
  output logic [PC_W-1:0]        pop_pc_o,
  output logic [INSTR_W-1:0]     pop_instr_o,
  input  logic                   pop_ready_i,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AddrW = $clog2(DEPTH);
  localparam int CntW  = AddrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [PC_W-1:0]    pcMem    [DEPTH];
  logic [INSTR_W-1:0] instrMem [DEPTH];

  logic [AddrW-1:0] head;
  logic [AddrW-1:0] tail;
  logic [CntW-1:0]  count;

  logic notEmpty;
  logic notFull;
  logic bypassHit;
  logic pushFire;
  logic popFire;
  logic doWrite;
  logic doAdvance;

  // Handshake and head-selection logic; ready depends on registered count only.
  always_comb begin
    notEmpty  = (count != '0);
    notFull   = (count != FullCnt);
    bypassHit = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypassHit = reset && !flush_i && !notEmpty && push_valid_i;
`endif
    push_ready_o = reset && notFull;
    pop_valid_o  = (reset && notEmpty) || bypassHit;
    pop_pc_o     = bypassHit ? push_pc_i : pcMem[head];
    pop_instr_o  = bypassHit ? push_instr_i : instrMem[head];
    pushFire     = push_valid_i && push_ready_o;
    popFire      = pop_valid_o && pop_ready_i;
    // A bypassed entry consumed this cycle never lands in storage.
    doWrite      = pushFire && !(bypassHit && pop_ready_i);
    doAdvance    = popFire && notEmpty;
    count_o      = count;
  end

  // Pointer and occupancy state; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (doWrite) begin
        tail <= tail + 1'b1;
      end
      if (doAdvance) begin
        head <= head + 1'b1;
      end
      case ({doWrite, doAdvance})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset, left intact on flush.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pcMem[i]    <= '0;
        instrMem[i] <= '0;
      end
    end else if (!flush_i && doWrite) begin
      pcMem[tail]    <= push_pc_i;
      instrMem[tail] <= push_instr_i;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scoreboard bench for fetch_queue.
// Expected entries queue on accepted push, compare on pop.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        pushValid = 1'b0;
  logic [63:0] pushPc = '0;
  logic [31:0] pushInstr = '0;
  logic        pushReady;
  logic        popValid;
  logic [63:0] popPc;
  logic [31:0] popInstr;
  logic        popReady = 1'b0;
  logic [3:0]  count;

  int nTests = 0;
  int nFail  = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t sb[$];

  fetch_queue #(.DEPTH(8), .PC_W(64), .INSTR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush),
    .push_valid_i (pushValid),
    .push_pc_i    (pushPc),
    .push_instr_i (pushInstr),
    .push_ready_o (pushReady),
    .pop_valid_o  (popValid),
    .pop_pc_o     (popPc),
    .pop_instr_o  (popInstr),
    .pop_ready_i  (popReady),
    .count_o      (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mkIns(input logic [63:0] pc);
    return pc[31:0] ^ 32'hA5C3_0F13;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic pv, input logic [63:0] pc,
                       input logic pr, input logic fl);
    logic expRdy;
    logic expVal;
    logic byp;
    logic pushF;
    logic popF;
    ent_t e;
    pushValid = pv;
    pushPc    = pc;
    pushInstr = mkIns(pc);
    popReady  = pr;
    flush     = fl;
    @(negedge clk);
    expRdy = (sb.size() != 8);
    byp    = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (sb.size() == 0) && pv && !fl;
`endif
    expVal = (sb.size() != 0) || byp;
    chk("pushReady", 64'(pushReady), 64'(expRdy));
    chk("popValid", 64'(popValid), 64'(expVal));
    if (expVal) begin
      if (byp) begin
        e.pc  = pc;
        e.ins = mkIns(pc);
      end else begin
        e = sb[0];
      end
      chk("popPc", popPc, e.pc);
      chk("popInstr", 64'(popInstr), 64'(e.ins));
    end
    pushF = pv && expRdy;
    popF  = expVal && pr;
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else begin
      if (popF && !byp) void'(sb.pop_front());
      if (pushF && !(byp && pr)) begin
        e.pc  = pc;
        e.ins = mkIns(pc);
        sb.push_back(e);
      end
    end
    #1;
    chk("count", 64'(count), 64'(sb.size()));
  endtask

  task automatic resetCycles(input int n);
    reset     = 1'b0;
    pushValid = 1'b1;
    pushPc    = 64'hDEAD;
    pushInstr = mkIns(64'hDEAD);
    popReady  = 1'b1;
    flush     = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rstPushReady", 64'(pushReady), 64'd0);
      chk("rstPopValid", 64'(popValid), 64'd0);
      @(posedge clk);
      #1;
    end
    sb.delete();
    reset     = 1'b1;
    pushValid = 1'b0;
    popReady  = 1'b0;
    @(negedge clk);
    chk("postRstCount", 64'(count), 64'd0);
    chk("postRstReady", 64'(pushReady), 64'd1);
    chk("postRstValid", 64'(popValid), 64'd0);
    chk("postRstPc", popPc, 64'd0);
    chk("postRstInstr", 64'(popInstr), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 32) begin
      cycle(1'b0, 64'd0, 1'b1, 1'b0);
      guard++;
    end
    chk("drainBound", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    resetCycles(2);

    for (int i = 0; i < 8; i++) cycle(1'b1, 64'(i * 4), 1'b0, 1'b0);
    cycle(1'b1, 64'h20, 1'b0, 1'b0);
    cycle(1'b1, 64'h20, 1'b1, 1'b0);
    drain();
    cycle(1'b0, 64'd0, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) cycle(1'b1, 64'h1000 + 64'(i * 4), 1'b0, 1'b0);
    drain();
    for (int i = 0; i < 6; i++) cycle(1'b1, 64'h2000 + 64'(i * 4), 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 3; i++) cycle(1'b1, 64'h3000 + 64'(i * 4), 1'b0, 1'b0);
    cycle(1'b1, 64'h300C, 1'b1, 1'b0);
    cycle(1'b1, 64'h3010, 1'b1, 1'b0);
    drain();

    for (int i = 0; i < 5; i++) cycle(1'b1, 64'h4000 + 64'(i * 4), 1'b0, 1'b0);
    cycle(1'b1, 64'h4100, 1'b1, 1'b1);
    cycle(1'b1, 64'h100, 1'b0, 1'b0);
    cycle(1'b1, 64'h104, 1'b1, 1'b0);
    drain();

    cycle(1'b1, 64'h40, 1'b1, 1'b0);
    drain();
    cycle(1'b0, 64'd0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) cycle(1'b1, 64'h5000 + 64'(i * 4), 1'b0, 1'b0);
    resetCycles(1);
    cycle(1'b1, 64'h6000, 1'b0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
